de_reg: RTL and testbench

D/E pipeline register of the five-stage MIPS core. It captures the decoded instruction, register operands, the 32-bit extended immediate and the exception state at the end of the D stage, and presents them to the E stage (ALU/MDU) one cycle later. It implements stall-bubble insertion, exception/interrupt flush and the Tnew countdown used by the hazard unit.

---
 rtl/de_reg_pkg.sv | 25 ++
 rtl/de_reg_pipe_field.sv | 29 ++
 rtl/de_reg.sv | 70 +++++++
 tb/tb_de_reg.sv | 139 +++++++++++++
 4 files changed

// File: rtl/de_reg_pkg.sv
// rtl/de_reg_pkg.sv - shared pipeline constants, exception codes and Tnew encoding
package de_reg_pkg;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    typedef logic [1:0] tnew_t;
    localparam tnew_t TNEW_0 = 2'd0;
    localparam tnew_t TNEW_1 = 2'd1;
    localparam tnew_t TNEW_2 = 2'd2;
    localparam tnew_t TNEW_3 = 2'd3;

    // One stage of progress: the result is one cycle closer, never below ready.
    function automatic tnew_t tnew_step(input tnew_t t);
        return (t == TNEW_0) ? TNEW_0 : tnew_t'(t - 2'd1);
    endfunction

endpackage

// File: rtl/de_reg_pipe_field.sv
// rtl/de_reg_pipe_field.sv - one pipeline-register field with reset, flush and bubble values
module pipe_field #(
    parameter int           W           = 32,
    parameter logic [W-1:0] RST_VAL     = '0,
    parameter logic [W-1:0] FLUSH_VAL   = '0,
    parameter logic [W-1:0] BUBBLE_VAL  = '0,
    parameter bit           BUBBLE_PASS = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // BUBBLE_PASS fields keep tracking D during a bubble (PC/BD for EPC).
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= RST_VAL;
        else if (flush)
            q <= FLUSH_VAL;
        else if (bubble)
            q <= BUBBLE_PASS ? d : BUBBLE_VAL;
        else
            q <= d;
    end

endmodule

// File: rtl/de_reg.sv
// rtl/de_reg.sv - D/E pipeline register with bubble insertion, flush and Tnew countdown
module de_reg
    import de_reg_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        stall,
    input  logic [31:0] D_pc,
    input  logic [31:0] D_instr,
    input  logic [31:0] D_rs_data,
    input  logic [31:0] D_rt_data,
    input  logic [31:0] D_imm32,
    input  logic [4:0]  D_exc_code,
    input  logic        D_bd,
    input  logic [1:0]  D_tnew,
    output logic [31:0] E_pc,
    output logic [31:0] E_instr,
    output logic [31:0] E_rs_data,
    output logic [31:0] E_rt_data,
    output logic [31:0] E_imm32,
    output logic [4:0]  E_exc_code,
    output logic        E_bd,
    output logic [1:0]  E_tnew,
    output logic        E_valid
);

    tnew_t d_tnew_next;
    assign d_tnew_next = tnew_step(D_tnew);

    pipe_field #(.W(32), .RST_VAL(RESET_PC), .FLUSH_VAL(HANDLER_PC), .BUBBLE_PASS(1'b1)) u_pc (
        .clk(clk), .reset(reset), .flush(req), .bubble(stall), .d(D_pc), .q(E_pc)
    );

    pipe_field #(.W(32)) u_instr (
        .clk(clk), .reset(reset), .flush(req), .bubble(stall), .d(D_instr), .q(E_instr)
    );

    pipe_field #(.W(32)) u_rs (
        .clk(clk), .reset(reset), .flush(req), .bubble(stall), .d(D_rs_data), .q(E_rs_data)
    );

    pipe_field #(.W(32)) u_rt (
        .clk(clk), .reset(reset), .flush(req), .bubble(stall), .d(D_rt_data), .q(E_rt_data)
    );

    pipe_field #(.W(32)) u_imm (
        .clk(clk), .reset(reset), .flush(req), .bubble(stall), .d(D_imm32), .q(E_imm32)
    );

    pipe_field #(.W(5)) u_exc (
        .clk(clk), .reset(reset), .flush(req), .bubble(stall), .d(D_exc_code), .q(E_exc_code)
    );

    pipe_field #(.W(1), .BUBBLE_PASS(1'b1)) u_bd (
        .clk(clk), .reset(reset), .flush(req), .bubble(stall), .d(D_bd), .q(E_bd)
    );

    pipe_field #(.W(2)) u_tnew (
        .clk(clk), .reset(reset), .flush(req), .bubble(stall), .d(d_tnew_next), .q(E_tnew)
    );

    pipe_field #(.W(1)) u_valid (
        .clk(clk), .reset(reset), .flush(req), .bubble(stall), .d(1'b1), .q(E_valid)
    );

endmodule

// File: tb/tb_de_reg.sv
// tb/tb_de_reg.sv - table-driven self-checking bench for de_reg
module tb_de_reg;

    logic        clk = 1'b0;
    logic        reset, req, stall;
    logic [31:0] D_pc, D_instr, D_rs_data, D_rt_data, D_imm32;
    logic [4:0]  D_exc_code;
    logic        D_bd;
    logic [1:0]  D_tnew;
    logic [31:0] E_pc, E_instr, E_rs_data, E_rt_data, E_imm32;
    logic [4:0]  E_exc_code;
    logic        E_bd;
    logic [1:0]  E_tnew;
    logic        E_valid;

    int tests = 0;
    int errors = 0;

    always #5 clk = ~clk;

    de_reg dut (
        .clk(clk), .reset(reset), .req(req), .stall(stall),
        .D_pc(D_pc), .D_instr(D_instr), .D_rs_data(D_rs_data), .D_rt_data(D_rt_data),
        .D_imm32(D_imm32), .D_exc_code(D_exc_code), .D_bd(D_bd), .D_tnew(D_tnew),
        .E_pc(E_pc), .E_instr(E_instr), .E_rs_data(E_rs_data), .E_rt_data(E_rt_data),
        .E_imm32(E_imm32), .E_exc_code(E_exc_code), .E_bd(E_bd), .E_tnew(E_tnew),
        .E_valid(E_valid)
    );

    typedef struct packed {
        logic        req;
        logic        stall;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm;
        logic [4:0]  exc;
        logic        bd;
        logic [1:0]  tnew;
        logic [31:0] x_pc;
        logic [31:0] x_instr;
        logic [31:0] x_rs;
        logic [31:0] x_rt;
        logic [31:0] x_imm;
        logic [4:0]  x_exc;
        logic        x_bd;
        logic [1:0]  x_tnew;
        logic        x_valid;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                           input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                           input logic [4:0] exc, input logic bd, input logic [1:0] tnew,
                           input logic valid);
        chk({tag, ".pc"},    E_pc,       pc);
        chk({tag, ".instr"}, E_instr,    instr);
        chk({tag, ".rs"},    E_rs_data,  rs);
        chk({tag, ".rt"},    E_rt_data,  rt);
        chk({tag, ".imm"},   E_imm32,    imm);
        chk({tag, ".exc"},   32'(E_exc_code), 32'(exc));
        chk({tag, ".bd"},    32'(E_bd),   32'(bd));
        chk({tag, ".tnew"},  32'(E_tnew), 32'(tnew));
        chk({tag, ".valid"}, 32'(E_valid), 32'(valid));
    endtask

    task automatic drive(input vec_t v);
        req = v.req; stall = v.stall;
        D_pc = v.pc; D_instr = v.instr; D_rs_data = v.rs; D_rt_data = v.rt;
        D_imm32 = v.imm; D_exc_code = v.exc; D_bd = v.bd; D_tnew = v.tnew;
    endtask

    initial begin
        //            req   stall pc            instr         rs            rt            imm           exc    bd    tnew  | x_pc          x_instr       x_rs          x_rt          x_imm         x_exc  x_bd  x_tn  x_v
        vecs[0]  = '{1'b0, 1'b0, 32'h0000_3004, 32'h2008_FFFF, 32'h1111_1111, 32'h2222_2222, 32'hFFFF_FFFF, 5'd0,  1'b0, 2'd2, 32'h0000_3004, 32'h2008_FFFF, 32'h1111_1111, 32'h2222_2222, 32'hFFFF_FFFF, 5'd0, 1'b0, 2'd1, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 32'h0000_3008, 32'h0109_5020, 32'h0000_0005, 32'h0000_0007, 32'h0000_5020, 5'd0,  1'b0, 2'd0, 32'h0000_3008, 32'h0109_5020, 32'h0000_0005, 32'h0000_0007, 32'h0000_5020, 5'd0, 1'b0, 2'd0, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 32'h0000_300C, 32'h0000_0018, 32'hAAAA_5555, 32'h5555_AAAA, 32'h0000_0018, 5'd0,  1'b0, 2'd3, 32'h0000_300C, 32'h0000_0018, 32'hAAAA_5555, 32'h5555_AAAA, 32'h0000_0018, 5'd0, 1'b0, 2'd2, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_3010, 32'h8C08_0004, 32'h1234_5678, 32'h8765_4321, 32'h0000_0004, 5'd0,  1'b1, 2'd3, 32'h0000_3010, 32'h0,         32'h0,         32'h0,         32'h0,         5'd0, 1'b1, 2'd0, 1'b0};
        vecs[4]  = vecs[3];
        vecs[5]  = vecs[3];
        vecs[6]  = '{1'b0, 1'b0, 32'h0000_3010, 32'h8C08_0004, 32'h1234_5678, 32'h8765_4321, 32'h0000_0004, 5'd0,  1'b1, 2'd3, 32'h0000_3010, 32'h8C08_0004, 32'h1234_5678, 32'h8765_4321, 32'h0000_0004, 5'd0, 1'b1, 2'd2, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 32'h0000_3014, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0000_0001, 5'd10, 1'b1, 2'd2, 32'h0000_4180, 32'h0,         32'h0,         32'h0,         32'h0,         5'd0, 1'b0, 2'd0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 32'h0000_3001, 32'h8C09_0000, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 5'd4,  1'b0, 2'd1, 32'h0000_3001, 32'h8C09_0000, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 5'd4, 1'b0, 2'd0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 32'h0000_3020, 32'h0000_000C, 32'h0000_00FF, 32'h0000_0F00, 32'h0000_000C, 5'd12, 1'b0, 2'd2, 32'h0000_3020, 32'h0,         32'h0,         32'h0,         32'h0,         5'd0, 1'b0, 2'd0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_3024, 32'h0000_000C, 32'h0000_00FF, 32'h0000_0F00, 32'h0000_000C, 5'd0,  1'b1, 2'd3, 32'h0000_4180, 32'h0,         32'h0,         32'h0,         32'h0,         5'd0, 1'b0, 2'd0, 1'b0};

        reset = 1'b0;
        drive(vecs[0]);
        #2 reset = 1'b1;
        #1 chk_all("reset", 32'h0000_3000, 0, 0, 0, 0, 5'd0, 1'b0, 2'd0, 1'b0);

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].x_pc, vecs[i].x_instr, vecs[i].x_rs,
                    vecs[i].x_rt, vecs[i].x_imm, vecs[i].x_exc, vecs[i].x_bd,
                    vecs[i].x_tnew, vecs[i].x_valid);
        end

        // Load a real instruction, then hit it with reset between edges.
        @(negedge clk);
        drive(vecs[0]);
        @(posedge clk);
        #1 chk("pre_async.valid", 32'(E_valid), 32'd1);
        #2 reset = 1'b1;
        #1 chk_all("async", 32'h0000_3000, 0, 0, 0, 0, 5'd0, 1'b0, 2'd0, 1'b0);

        // Reset released with req pending: the first edge flushes.
        @(negedge clk);
        req = 1'b1;
        reset = 1'b0;
        @(posedge clk);
        #1 chk_all("rel_req", 32'h0000_4180, 0, 0, 0, 0, 5'd0, 1'b0, 2'd0, 1'b0);

        @(negedge clk);
        drive(vecs[8]);
        @(posedge clk);
        #1 chk_all("resume", 32'h0000_3001, 32'h8C09_0000, 32'h1, 32'h2, 32'h0, 5'd4, 1'b0, 2'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
